// File: rtl/fetch_unit_pkg.sv
// Shared CPU definitions for the fetch stage: FSM encoding and default vector addresses.
package fetch_unit_pkg;

  localparam int unsigned DEF_ADDR_W       = 32;
  localparam int unsigned DEF_INSTR_W      = 16;
  localparam int unsigned DEF_RST_VEC_ADDR = 0;
  localparam int unsigned DEF_INT_VEC_ADDR = 2;

  typedef enum logic [1:0] {
    VEC_LO  = 2'd0,
    VEC_HI  = 2'd1,
    VEC_CAP = 2'd2,
    RUN     = 2'd3
  } fetch_state_e;

endpackage

// File: rtl/program_counter_p.sv
// Program counter register with synchronous load (priority) and increment enable.
module program_counter_p #(
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              load,
  input  logic [ADDR_W-1:0] load_val,
  output logic [ADDR_W-1:0] pc
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc <= '0;
    end else if (load) begin
      pc <= load_val;
    end else if (en) begin
      pc <= pc + ADDR_W'(1);
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: vector load from memory, sequential fetch with stall skid,
// redirect handling and interrupt acceptance.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int unsigned        ADDR_W       = DEF_ADDR_W,
  parameter int unsigned        INSTR_W      = DEF_INSTR_W,
  parameter logic [ADDR_W-1:0]  RST_VEC_ADDR = ADDR_W'(DEF_RST_VEC_ADDR),
  parameter logic [ADDR_W-1:0]  INT_VEC_ADDR = ADDR_W'(DEF_INT_VEC_ADDR),
  parameter logic [INSTR_W-1:0] NOP_WORD     = '0
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_stall,
  input  logic               i_redirect,
  input  logic [ADDR_W-1:0]  i_redirect_pc,
  input  logic               i_interrupt,
  output logic [ADDR_W-1:0]  o_imem_addr,
  output logic               o_imem_en,
  input  logic [INSTR_W-1:0] i_imem_rdata,
  output logic [INSTR_W-1:0] o_instr,
  output logic [ADDR_W-1:0]  o_instr_pc,
  output logic               o_valid,
  output logic               o_int_taken,
  output logic [ADDR_W-1:0]  o_int_ret_pc
);

  if (ADDR_W != 2 * INSTR_W) begin : g_width_check
    $error("fetch_unit: ADDR_W must equal 2*INSTR_W");
  end

  fetch_state_e state_q, state_d;

  logic [ADDR_W-1:0]  pc;
  logic [ADDR_W-1:0]  vec_base_q;
  logic [INSTR_W-1:0] lo_word_q;
  logic               pending_q;
  logic               inflight_q;
  logic [ADDR_W-1:0]  inflight_pc_q;
  logic               skid_valid_q;
  logic [INSTR_W-1:0] skid_word_q;
  logic [ADDR_W-1:0]  skid_pc_q;

  logic               int_pend_c;
  logic               imem_en_c;
  logic [ADDR_W-1:0]  imem_addr_c;
  logic               pc_inc_c;
  logic               pc_load_c;
  logic [ADDR_W-1:0]  pc_load_val_c;
  logic               issue_c;
  logic               redirect_c;
  logic               accept_c;

  // An interrupt raised this cycle can be accepted in the same cycle.
  assign int_pend_c = pending_q | i_interrupt;

  program_counter_p #(
    .ADDR_W (ADDR_W)
  ) u_pc (
    .clk      (i_clk),
    .rst_n    (i_reset),
    .en       (pc_inc_c),
    .load     (pc_load_c),
    .load_val (pc_load_val_c),
    .pc       (pc)
  );

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q <= VEC_LO;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and per-cycle control decode.
  always_comb begin
    state_d       = state_q;
    imem_en_c     = 1'b0;
    imem_addr_c   = pc;
    pc_inc_c      = 1'b0;
    pc_load_c     = 1'b0;
    pc_load_val_c = i_redirect_pc;
    issue_c       = 1'b0;
    redirect_c    = 1'b0;
    accept_c      = 1'b0;
    case (state_q)
      VEC_LO: begin
        imem_en_c   = 1'b1;
        imem_addr_c = vec_base_q;
        state_d     = VEC_HI;
      end
      VEC_HI: begin
        imem_en_c   = 1'b1;
        imem_addr_c = vec_base_q + ADDR_W'(1);
        state_d     = VEC_CAP;
      end
      VEC_CAP: begin
        pc_load_c     = 1'b1;
        pc_load_val_c = ADDR_W'({i_imem_rdata, lo_word_q});
        state_d       = RUN;
      end
      RUN: begin
        if (i_redirect) begin
          redirect_c    = 1'b1;
          pc_load_c     = 1'b1;
          pc_load_val_c = i_redirect_pc;
        end else if (!i_stall) begin
          if (int_pend_c) begin
            accept_c = 1'b1;
            state_d  = VEC_LO;
          end else begin
            issue_c   = 1'b1;
            imem_en_c = 1'b1;
            pc_inc_c  = 1'b1;
          end
        end
      end
      default: state_d = VEC_LO;
    endcase
  end

  // Memory is quiet while reset is held even though the FSM sits in VEC_LO.
  assign o_imem_en   = imem_en_c & i_reset;
  assign o_imem_addr = imem_addr_c;

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      vec_base_q    <= RST_VEC_ADDR;
      lo_word_q     <= '0;
      pending_q     <= 1'b0;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
      skid_valid_q  <= 1'b0;
      skid_word_q   <= '0;
      skid_pc_q     <= '0;
      o_instr       <= NOP_WORD;
      o_instr_pc    <= '0;
      o_valid       <= 1'b0;
      o_int_taken   <= 1'b0;
      o_int_ret_pc  <= '0;
    end else begin
      o_int_taken <= accept_c;
      pending_q   <= accept_c ? 1'b0 : int_pend_c;
      inflight_q  <= issue_c;
      if (issue_c) begin
        inflight_pc_q <= pc;
      end
      if (state_q == VEC_HI) begin
        lo_word_q <= i_imem_rdata;
      end
      if (accept_c) begin
        vec_base_q   <= INT_VEC_ADDR;
        o_int_ret_pc <= pc;
      end

      if (redirect_c || accept_c) begin
        skid_valid_q <= 1'b0;
        o_valid      <= 1'b0;
        o_instr      <= NOP_WORD;
      end else if (state_q == RUN && i_stall) begin
        // Park the returning word so the hold does not lose it.
        if (inflight_q) begin
          skid_valid_q <= 1'b1;
          skid_word_q  <= i_imem_rdata;
          skid_pc_q    <= inflight_pc_q;
        end
      end else if (state_q == RUN) begin
        if (skid_valid_q) begin
          skid_valid_q <= 1'b0;
          o_valid      <= 1'b1;
          o_instr      <= skid_word_q;
          o_instr_pc   <= skid_pc_q;
        end else if (inflight_q) begin
          o_valid    <= 1'b1;
          o_instr    <= i_imem_rdata;
          o_instr_pc <= inflight_pc_q;
        end else begin
          o_valid <= 1'b0;
          o_instr <= NOP_WORD;
        end
      end
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: scoreboard of expected fetch addresses plus
// a redirect vector table and directed stall/interrupt/reset sequences.
module tb_fetch_unit;

  localparam logic [15:0] NOP = 16'hDEAD;

  logic        clk = 1'b0;
  logic        i_reset = 1'b0;
  logic        i_stall = 1'b0;
  logic        i_redirect = 1'b0;
  logic [31:0] i_redirect_pc = '0;
  logic        i_interrupt = 1'b0;
  logic [31:0] o_imem_addr;
  logic        o_imem_en;
  logic [15:0] imem_rdata = '0;
  logic [15:0] o_instr;
  logic [31:0] o_instr_pc;
  logic        o_valid;
  logic        o_int_taken;
  logic [31:0] o_int_ret_pc;

  int tests = 0;
  int failed = 0;

  logic [31:0] exp_q[$];
  logic        stall_at_edge = 1'b0;
  logic        redir_at_edge = 1'b0;
  logic        prev_valid = 1'b0;
  logic [31:0] prev_pc = '0;
  logic [15:0] prev_instr = '0;

  always #5 clk = ~clk;

  fetch_unit #(
    .ADDR_W       (32),
    .INSTR_W      (16),
    .RST_VEC_ADDR (32'd0),
    .INT_VEC_ADDR (32'd2),
    .NOP_WORD     (NOP)
  ) dut (
    .i_clk         (clk),
    .i_reset       (i_reset),
    .i_stall       (i_stall),
    .i_redirect    (i_redirect),
    .i_redirect_pc (i_redirect_pc),
    .i_interrupt   (i_interrupt),
    .o_imem_addr   (o_imem_addr),
    .o_imem_en     (o_imem_en),
    .i_imem_rdata  (imem_rdata),
    .o_instr       (o_instr),
    .o_instr_pc    (o_instr_pc),
    .o_valid       (o_valid),
    .o_int_taken   (o_int_taken),
    .o_int_ret_pc  (o_int_ret_pc)
  );

  function automatic logic [15:0] mem_word(input logic [31:0] a);
    case (a)
      32'd0:   mem_word = 16'h0010;
      32'd1:   mem_word = 16'h0000;
      32'd2:   mem_word = 16'h0080;
      32'd3:   mem_word = 16'h0000;
      default: mem_word = a[15:0] ^ 16'h5A5A;
    endcase
  endfunction

  // Synchronous instruction memory.
  always @(posedge clk) begin
    if (o_imem_en) imem_rdata <= mem_word(o_imem_addr);
  end

  always @(posedge clk) begin
    stall_at_edge <= i_stall;
    redir_at_edge <= i_redirect;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Output monitor: pops the scoreboard on every fresh valid word, checks holds and NOPs.
  always @(negedge clk) begin
    if (i_reset) begin
      if (o_valid && !stall_at_edge) begin
        if (exp_q.size() == 0) begin
          tests++;
          failed++;
          $display("FAIL sb_unexpected: got pc %h with empty scoreboard", o_instr_pc);
        end else begin
          logic [31:0] e;
          e = exp_q.pop_front();
          chk("sb_pc", o_instr_pc, e);
          chk("sb_instr", 32'(o_instr), 32'(mem_word(e)));
        end
      end
      if (stall_at_edge && !redir_at_edge) begin
        chk("stall_hold_valid", 32'(o_valid), 32'(prev_valid));
        chk("stall_hold_pc", o_instr_pc, prev_pc);
        chk("stall_hold_instr", 32'(o_instr), 32'(prev_instr));
      end
      if (!o_valid) chk("nop_when_invalid", 32'(o_instr), 32'(NOP));
    end
    prev_valid = o_valid;
    prev_pc    = o_instr_pc;
    prev_instr = o_instr;
  end

  task automatic cyc();
    @(negedge clk);
    #1;
  endtask

  task automatic push_run(input logic [31:0] start);
    exp_q.delete();
    for (int i = 0; i < 32; i++) exp_q.push_back(start + 32'(i));
  endtask

  task automatic wait_valid(input int budget, output int n);
    n = 0;
    while (!(o_valid && !stall_at_edge) && n < budget) begin
      cyc();
      n++;
    end
    if (n >= budget) begin
      tests++;
      failed++;
      $display("FAIL wait_valid: no valid word within %0d cycles", budget);
    end
  endtask

  task automatic do_reset_release();
    i_reset     = 1'b0;
    i_stall     = 1'b0;
    i_redirect  = 1'b0;
    i_interrupt = 1'b0;
    #1;
    chk("rst_imem_en_async", 32'(o_imem_en), 32'd0);
    chk("rst_valid_async", 32'(o_valid), 32'd0);
    cyc();
    cyc();
    exp_q.delete();
    chk("rst_valid", 32'(o_valid), 32'd0);
    chk("rst_instr", 32'(o_instr), 32'(NOP));
    chk("rst_instr_pc", o_instr_pc, 32'd0);
    chk("rst_int_taken", 32'(o_int_taken), 32'd0);
    chk("rst_int_ret_pc", o_int_ret_pc, 32'd0);
    chk("rst_imem_en", 32'(o_imem_en), 32'd0);
    push_run(32'h10);
    i_reset = 1'b1;
    #1;
    chk("vec_lo_en", 32'(o_imem_en), 32'd1);
    chk("vec_lo_addr", o_imem_addr, 32'd0);
    cyc();
    chk("vec_hi_en", 32'(o_imem_en), 32'd1);
    chk("vec_hi_addr", o_imem_addr, 32'd1);
    cyc();
    chk("vec_cap_en", 32'(o_imem_en), 32'd0);
    cyc();
    chk("run_first_en", 32'(o_imem_en), 32'd1);
    chk("run_first_addr", o_imem_addr, 32'h10);
    cyc();
    chk("edge4_valid", 32'(o_valid), 32'd0);
    cyc();
    chk("edge5_valid", 32'(o_valid), 32'd1);
    chk("edge5_pc", o_instr_pc, 32'h10);
    chk("edge5_instr", 32'(o_instr), 32'h5A4A);
  endtask

  task automatic do_redirect(input logic [31:0] tgt, input bit with_stall, output int lat);
    push_run(tgt);
    i_redirect    = 1'b1;
    i_redirect_pc = tgt;
    i_stall       = with_stall;
    cyc();
    chk("redir_squash", 32'(o_valid), 32'd0);
    chk("redir_nop", 32'(o_instr), 32'(NOP));
    i_redirect = 1'b0;
    if (with_stall) begin
      cyc();
      cyc();
      i_stall = 1'b0;
    end
    wait_valid(16, lat);
  endtask

  typedef struct {
    logic [31:0] target;
    bit          with_stall;
    logic [15:0] exp_instr;
    int          exp_lat;
  } redir_vec_t;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    redir_vec_t  tbl[4];
    int          lat;
    int          n;
    logic [31:0] held_pc;

    tbl[0] = '{target: 32'h0000_0040, with_stall: 1'b1, exp_instr: 16'h5A1A, exp_lat: 2};
    tbl[1] = '{target: 32'h0000_1234, with_stall: 1'b0, exp_instr: 16'h486E, exp_lat: 2};
    tbl[2] = '{target: 32'hFFFF_FFFE, with_stall: 1'b0, exp_instr: 16'hA5A4, exp_lat: 2};
    tbl[3] = '{target: 32'h0000_0050, with_stall: 1'b1, exp_instr: 16'h5A0A, exp_lat: 2};

    cyc();
    do_reset_release();
    for (int i = 0; i < 6; i++) cyc();

    // Three-cycle stall mid-stream; the monitor checks holds and continuity.
    i_stall = 1'b1;
    #1;
    chk("stall_en_low", 32'(o_imem_en), 32'd0);
    held_pc = o_instr_pc;
    cyc();
    cyc();
    cyc();
    chk("stall_pc_frozen", o_instr_pc, held_pc);
    i_stall = 1'b0;
    for (int i = 0; i < 6; i++) cyc();

    foreach (tbl[k]) begin
      do_redirect(tbl[k].target, tbl[k].with_stall, lat);
      chk("tbl_first_pc", o_instr_pc, tbl[k].target);
      chk("tbl_first_instr", 32'(o_instr), 32'(tbl[k].exp_instr));
      chk("tbl_latency", 32'(lat), 32'(tbl[k].exp_lat));
      for (int i = 0; i < 4; i++) cyc();
    end

    // Interrupt while the next unissued address is 0x23.
    do_redirect(32'h21, 1'b0, lat);
    n = 0;
    while (!(o_imem_en && o_imem_addr == 32'h23) && n < 10) begin
      cyc();
      n++;
    end
    chk("int_reach_23", o_imem_addr, 32'h23);
    push_run(32'h80);
    i_interrupt = 1'b1;
    cyc();
    i_interrupt = 1'b0;
    chk("int_taken", 32'(o_int_taken), 32'd1);
    chk("int_ret_pc", o_int_ret_pc, 32'h23);
    chk("int_squash", 32'(o_valid), 32'd0);
    cyc();
    chk("int_taken_pulse", 32'(o_int_taken), 32'd0);
    chk("int_vec_hi_addr", o_imem_addr, 32'd3);
    wait_valid(16, lat);
    chk("int_first_pc", o_instr_pc, 32'h80);
    chk("int_first_instr", 32'(o_instr), 32'h5ADA);
    chk("int_latency", 32'(lat), 32'd4);
    for (int i = 0; i < 3; i++) cyc();

    // Redirect and interrupt together: redirect first, interrupt next cycle.
    push_run(32'h80);
    i_redirect    = 1'b1;
    i_redirect_pc = 32'h50;
    i_interrupt   = 1'b1;
    cyc();
    i_redirect  = 1'b0;
    i_interrupt = 1'b0;
    chk("ri_squash", 32'(o_valid), 32'd0);
    chk("ri_no_take_yet", 32'(o_int_taken), 32'd0);
    chk("ri_pc_loaded", o_imem_addr, 32'h50);
    chk("ri_accept_no_issue", 32'(o_imem_en), 32'd0);
    cyc();
    chk("ri_int_taken", 32'(o_int_taken), 32'd1);
    chk("ri_ret_pc", o_int_ret_pc, 32'h50);
    wait_valid(16, lat);
    chk("ri_first_pc", o_instr_pc, 32'h80);
    for (int i = 0; i < 3; i++) cyc();

    // Reset asserted while the interrupt vector sequence is in VEC_HI.
    push_run(32'h80);
    i_interrupt = 1'b1;
    cyc();
    i_interrupt = 1'b0;
    chk("mid_int_taken", 32'(o_int_taken), 32'd1);
    cyc();
    chk("mid_vec_hi_en", 32'(o_imem_en), 32'd1);
    chk("mid_vec_hi_addr", o_imem_addr, 32'd3);
    do_reset_release();
    for (int i = 0; i < 4; i++) cyc();

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 32, meaning PC and memory address width; it SHALL equal 2*INSTR_W.
REQ-002 The block SHALL have parameter INSTR_W, default 16, meaning instruction word width.
REQ-003 The block SHALL have parameter RST_VEC_ADDR, default 0, meaning the word address of the reset-vector low half; the high half is at +1.
REQ-004 The block SHALL have parameter INT_VEC_ADDR, default 2, meaning the word address of the interrupt-vector low half; the high half is at +1.
REQ-005 The block SHALL have parameter NOP_WORD, default 0, meaning the instruction value presented when o_valid=0.
REQ-006 The block SHALL have port i_clk, input, width 1, the single clock; all state SHALL update on its rising edge.
REQ-007 The block SHALL have port i_reset, input, width 1, an asynchronous active-low reset (0 = reset).
REQ-008 The block SHALL have port i_stall, input, width 1, a hold request from downstream.
REQ-009 The block SHALL have port i_redirect, input, width 1, the taken-branch/jump decision.
REQ-010 The block SHALL have port i_redirect_pc, input, width ADDR_W, the redirect target.
REQ-011 The block SHALL have port i_interrupt, input, width 1, an external interrupt request, sampled each cycle.
REQ-012 The block SHALL have port o_imem_addr, output, width ADDR_W, the synchronous instruction-memory read address.
REQ-013 The block SHALL have port o_imem_en, output, width 1, the memory read enable.
REQ-014 The block SHALL have port i_imem_rdata, input, width INSTR_W, read data valid one cycle after an enabled read.
REQ-015 The block SHALL have port o_instr, output, width INSTR_W, the fetched instruction.
REQ-016 The block SHALL have port o_instr_pc, output, width ADDR_W, the address of o_instr.
REQ-017 The block SHALL have port o_valid, output, width 1, asserted when o_instr is a real fetched instruction.
REQ-018 The block SHALL have port o_int_taken, output, width 1, a one-cycle pulse when an interrupt is accepted.
REQ-019 The block SHALL have port o_int_ret_pc, output, width ADDR_W, the return PC captured at interrupt acceptance, held until the next acceptance.

Function
REQ-020 The FSM SHALL have four states: VEC_LO (issue vector low), VEC_HI (issue vector high, capture low), VEC_CAP (capture high, load PC), RUN.
REQ-021 The vector sequence SHALL run VEC_LO->VEC_HI->VEC_CAP->RUN unconditionally, one cycle each; o_imem_en=1 in VEC_LO and VEC_HI and 0 in VEC_CAP.
REQ-022 In VEC_CAP the PC SHALL be loaded as {high word, low word}.
REQ-023 In RUN, each cycle with i_stall=0 SHALL issue a read at PC (o_imem_en=1) and set PC<=PC+1, wrapping modulo 2^ADDR_W.
REQ-024 The read returning in the cycle after an issue SHALL be registered to o_instr/o_instr_pc with o_valid=1, giving a total latency of 2 cycles from issue to output.
REQ-025 When i_stall=1 and i_redirect=0, the PC, o_instr, o_instr_pc, o_valid and any in-flight read SHALL hold, with o_imem_en=0; in-flight data SHALL be retained in a one-entry skid register, not lost.
REQ-026 A redirect in RUN SHALL override stall: PC<=i_redirect_pc, the in-flight/skid word squashed, and o_valid=0 on the next edge; the first redirected instruction SHALL appear 2 cycles after the redirect edge plus any stall cycles.
REQ-027 i_interrupt=1 SHALL set a pending flag; the flag SHALL persist until accepted.
REQ-028 An interrupt SHALL be accepted in RUN when pending=1, i_stall=0 and i_redirect=0.
REQ-029 On acceptance: o_int_ret_pc<=PC (the next unissued address), o_int_taken pulses, pending clears, the in-flight word is squashed, and the state goes to VEC_LO with vector base INT_VEC_ADDR.
REQ-030 When redirect and interrupt occur in the same cycle, redirect SHALL win and the interrupt SHALL stay pending.
REQ-031 i_redirect, i_stall and interrupt acceptance SHALL be ignored outside RUN, but i_interrupt SHALL still set pending.
REQ-032 Whenever o_valid=0, o_instr SHALL equal NOP_WORD.

Reset
REQ-033 While i_reset=0 the block SHALL enter VEC_LO with vector base RST_VEC_ADDR, with PC=0, o_valid=0, o_instr=NOP_WORD, o_instr_pc=0, o_int_taken=0, o_int_ret_pc=0, pending=0, skid empty, o_imem_en=0.
REQ-034 Reset asserted mid-sequence or mid-stall SHALL abort immediately; after release the reset-vector load SHALL restart from VEC_LO.

Structure
REQ-035 The FSM state encoding and default vector addresses SHALL live in the shared CPU package.
REQ-036 The PC register SHALL be one sub-module, program_counter_p, parametrised by ADDR_W, with enable and load ports.

Verification
REQ-037 Reset vector: mem[0]=0x0010, mem[1]=0x0000 -> issues at 0,1, then the first o_valid has o_instr_pc=0x00000010 on the 5th edge after release.
REQ-038 Stall: i_stall=1 for 3 cycles mid-stream -> o_instr/o_instr_pc frozen, no address skipped or duplicated after release.
REQ-039 Redirect during stall: redirect to 0x40 -> o_valid=0 next edge, next valid o_instr_pc=0x40.
REQ-040 Interrupt: pulse at PC=0x23, mem[2..3]=0x0080,0 -> o_int_taken pulse, o_int_ret_pc=0x23, next valid PC=0x80.
REQ-041 Redirect+interrupt in the same cycle: redirect to 0x50 is taken; the interrupt is accepted the next cycle with o_int_ret_pc=0x50.
REQ-042 Wrap: PC=0xFFFFFFFF -> next issued address 0x00000000; an async reset mid-VEC_HI restarts the sequence from VEC_LO.
